// File: rtl/game_pkg.sv
// game_pkg: playfield constants and the vertical motion state encoding
// shared by the motion controller, background lookup and draw logic.
package game_pkg;

  localparam int MAX_X = 320;  // playfield width in pixels
  localparam int MAX_Y = 240;  // playfield height in pixels

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } motion_state_e;

endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running divider. Counts 0..TICK_DIV-1 and wraps.
// Ports:
//   clock      in  system clock
//   resetn     in  async active-low reset
//   tick_cycle out high (combinationally) on the cycle the count is TICK_DIV-1
module tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clock,
  input  logic resetn,
  output logic tick_cycle
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)            r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + CW'(1);
  end

  assign tick_cycle = (r_cnt == LAST);

endmodule

// File: rtl/character_motion.sv
// character_motion: player motion controller. Tick divider, edge-captured
// jump request, GROUND/RISE/FALL vertical FSM and clamped horizontal steps.
// Optional feature macro: CHARACTER_MOTION_DOUBLE_JUMP_EN (one air jump per
// ground contact).
// Ports:
//   clock, resetn        clock / async active-low reset
//   move_right/left      level key inputs
//   jump_req             level; only its rising edge is used
//   ground_below         solid pixel under feet, sampled on tick cycles
//   pos_x, pos_y         sprite origin
//   state                GROUND=0, RISE=1, FALL=2
//   tick                 one-cycle pulse per motion tick (registered)
//   landed               one-cycle pulse on FALL->GROUND
module character_motion
  import game_pkg::*;
#(
  parameter int TICK_DIV    = 833333,
  parameter int X_W         = 10,
  parameter int Y_W         = 10,
  parameter int MAX_X       = game_pkg::MAX_X,
  parameter int MAX_Y       = game_pkg::MAX_Y,
  parameter int SPRITE_W    = 11,
  parameter int SPRITE_H    = 12,
  parameter int JUMP_HEIGHT = 40,
  parameter int START_X     = 0,
  parameter int START_Y     = 205
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           move_right,
  input  logic           move_left,
  input  logic           jump_req,
  input  logic           ground_below,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic [1:0]     state,
  output logic           tick,
  output logic           landed
);

  localparam logic [X_W-1:0] X_RIGHT = X_W'(MAX_X - SPRITE_W);
  localparam logic [Y_W-1:0] Y_FLOOR = Y_W'(MAX_Y - SPRITE_H);
  localparam logic [Y_W-1:0] JH      = Y_W'(JUMP_HEIGHT);

  logic          w_tick_cycle;
  logic          r_tick, r_landed;
  logic          r_jump_prev, r_jump_pend;
  logic          w_jump_edge, w_jump;
  logic [X_W-1:0] r_pos_x, w_x_next;
  logic [Y_W-1:0] r_pos_y, w_y_next, r_apex, w_apex_next;
  logic [Y_W-1:0] w_y_dec, w_apex_launch;
  motion_state_e r_state, w_state_next;
  logic          w_land;
`ifdef CHARACTER_MOTION_DOUBLE_JUMP_EN
  logic          r_air_jump, w_air_next;
`endif

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clock      (clock),
    .resetn     (resetn),
    .tick_cycle (w_tick_cycle)
  );

  // Jump capture. An edge on the tick cycle itself is seen through
  // w_jump_edge even though the pending flag is being cleared.
  assign w_jump_edge = jump_req & ~r_jump_prev;
  assign w_jump      = r_jump_pend | w_jump_edge;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_jump_prev <= 1'b0;
      r_jump_pend <= 1'b0;
    end else begin
      r_jump_prev <= jump_req;
      if (w_tick_cycle)     r_jump_pend <= 1'b0;
      else if (w_jump_edge) r_jump_pend <= 1'b1;
    end
  end

  // Horizontal stepping, clamped to the playfield.
  always_comb begin
    w_x_next = r_pos_x;
    if (move_right && !move_left && r_pos_x != X_RIGHT)
      w_x_next = r_pos_x + X_W'(1);
    else if (move_left && !move_right && r_pos_x != '0)
      w_x_next = r_pos_x - X_W'(1);
  end

  // Saturating helpers: y never wraps below 0, apex saturates at 0.
  assign w_y_dec       = (r_pos_y == '0) ? '0 : r_pos_y - Y_W'(1);
  assign w_apex_launch = (r_pos_y > JH) ? r_pos_y - JH : '0;

  // Vertical FSM next-state.
  always_comb begin
    w_state_next = r_state;
    w_y_next     = r_pos_y;
    w_apex_next  = r_apex;
    w_land       = 1'b0;
    case (r_state)
      GROUND: begin
        if (w_jump) begin
          w_state_next = RISE;
          w_apex_next  = w_apex_launch;
          w_y_next     = w_y_dec;
        end else if (!ground_below) begin
          w_state_next = FALL;
          w_y_next     = r_pos_y + Y_W'(1);
        end
      end
      RISE: begin
        w_y_next = w_y_dec;
        if (r_pos_y == '0 || w_y_dec == r_apex) w_state_next = FALL;
      end
      FALL: begin
        if (ground_below || r_pos_y == Y_FLOOR) begin
          w_state_next = GROUND;
          w_land       = 1'b1;
        end else begin
          w_y_next = r_pos_y + Y_W'(1);
        end
      end
      default: w_state_next = FALL;
    endcase
`ifdef CHARACTER_MOTION_DOUBLE_JUMP_EN
    w_air_next = r_air_jump;
    // Air jump overrides whatever RISE/FALL decided, including a landing.
    if (r_state != GROUND && w_jump && r_air_jump) begin
      w_state_next = RISE;
      w_apex_next  = w_apex_launch;
      w_y_next     = w_y_dec;
      w_land       = 1'b0;
      w_air_next   = 1'b0;
    end
    if (w_state_next == GROUND) w_air_next = 1'b1;
`endif
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= FALL;
      r_pos_x  <= X_W'(START_X);
      r_pos_y  <= Y_W'(START_Y);
      r_apex   <= '0;
      r_tick   <= 1'b0;
      r_landed <= 1'b0;
`ifdef CHARACTER_MOTION_DOUBLE_JUMP_EN
      r_air_jump <= 1'b1;
`endif
    end else begin
      r_tick   <= w_tick_cycle;
      r_landed <= w_tick_cycle & w_land;
      if (w_tick_cycle) begin
        r_state <= w_state_next;
        r_pos_x <= w_x_next;
        r_pos_y <= w_y_next;
        r_apex  <= w_apex_next;
`ifdef CHARACTER_MOTION_DOUBLE_JUMP_EN
        r_air_jump <= w_air_next;
`endif
      end
    end
  end

  assign pos_x  = r_pos_x;
  assign pos_y  = r_pos_y;
  assign state  = r_state;
  assign tick   = r_tick;
  assign landed = r_landed;

endmodule
